// File: rtl/output_grouper.sv
// Formats a cipher byte stream into fixed-length letter groups and lines,
// buffers the result in a FIFO and hands bytes one at a time to a UART transmitter.
module output_grouper #(
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 5,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_ready,
  input  logic [7:0] i_data,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_overflow
);

  localparam int CW = $clog2(GROUP_LEN + 1);
  localparam int GW = $clog2(GROUPS_PER_LINE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CHAR_LAST  = CW'(GROUP_LEN);
  localparam logic [GW-1:0] GROUP_LAST = GW'(GROUPS_PER_LINE - 1);
  localparam logic [AW:0]   DEPTH      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {F_IDLE, F_SEP, F_CR, F_LF, F_CHAR} front_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_HOLD, T_WAIT} tx_t;

  front_t        front_q, front_d;
  tx_t           tx_q, tx_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] char_cnt_q, char_cnt_d;
  logic [GW-1:0] group_cnt_q, group_cnt_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic          push, pop, full, empty;
  logic [7:0]    push_byte;

  function automatic logic is_letter(input logic [7:0] b);
    return (b >= 8'd65) && (b <= 8'd90);
  endfunction

  function automatic logic is_line_end(input logic [7:0] b);
    return (b == 8'd13) || (b == 8'd10);
  endfunction

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Front FSM: separators are decided at accept time but counters move only on pushes.
  always_comb begin
    front_d     = front_q;
    hold_d      = hold_q;
    char_cnt_d  = char_cnt_q;
    group_cnt_d = group_cnt_q;
    overflow_d  = overflow_q;
    push        = 1'b0;
    push_byte   = hold_q;
    case (front_q)
      F_IDLE: begin
        if (i_ready) begin
          hold_d = i_data;
          if (is_letter(i_data) && (char_cnt_q == CHAR_LAST))
            front_d = (group_cnt_q == GROUP_LAST) ? F_CR : F_SEP;
          else
            front_d = F_CHAR;
        end
      end
      F_SEP: begin
        if (!full) begin
          push        = 1'b1;
          push_byte   = 8'd32;
          group_cnt_d = group_cnt_q + GW'(1);
          char_cnt_d  = '0;
          front_d     = F_CHAR;
        end
      end
      F_CR: begin
        if (!full) begin
          push      = 1'b1;
          push_byte = 8'd13;
          front_d   = F_LF;
        end
      end
      F_LF: begin
        if (!full) begin
          push        = 1'b1;
          push_byte   = 8'd10;
          group_cnt_d = '0;
          char_cnt_d  = '0;
          front_d     = F_CHAR;
        end
      end
      F_CHAR: begin
        if (!full) begin
          push = 1'b1;
          if (is_letter(hold_q)) begin
            char_cnt_d = char_cnt_q + CW'(1);
          end else if (is_line_end(hold_q)) begin
            char_cnt_d  = '0;
            group_cnt_d = '0;
          end
          front_d = F_IDLE;
        end
      end
      default: front_d = F_IDLE;
    endcase
    if (i_ready && (front_q != F_IDLE))
      overflow_d = 1'b1;
  end

  // Tx FSM: the start pulse is registered, so it appears in the cycle after T_START is entered.
  always_comb begin
    tx_d       = tx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (tx_q)
      T_IDLE: begin
        if (!empty && !i_tx_busy) begin
          pop       = 1'b1;
          tx_data_d = fifo_mem[rd_ptr_q];
          tx_d      = T_START;
        end
      end
      T_START: begin
        tx_start_d = 1'b1;
        tx_d       = T_HOLD;
      end
      T_HOLD: tx_d = T_WAIT;
      T_WAIT: if (!i_tx_busy) tx_d = T_IDLE;
      default: tx_d = T_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      front_q     <= F_IDLE;
      tx_q        <= T_IDLE;
      char_cnt_q  <= '0;
      group_cnt_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
    end else begin
      front_q     <= front_d;
      tx_q        <= tx_d;
      char_cnt_q  <= char_cnt_d;
      group_cnt_q <= group_cnt_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
    end
  end

  // Payload storage carries no reset; emptiness is tracked by the control counters.
  always_ff @(posedge i_clock) begin
    hold_q <= hold_d;
    if (push)
      fifo_mem[wr_ptr_q] <= push_byte;
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_overflow = overflow_q;

endmodule
